// File: rtl/strb_gen_pkg.sv
// strb_gen_pkg: channel state and mode types shared by the strobe generator
package strb_gen_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} ch_state_e;
  typedef enum logic {PERIODIC, ONESHOT} mode_e;
endpackage

// File: rtl/strb_gen_ch.sv
// strb_gen_ch: one strobe channel with active/shadow divisor and down-counter
module strb_gen_ch
  import strb_gen_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             mode_i,
  input  logic             en_i,
  output logic             strb_o,
  output logic             busy_o,
  output logic             pend_o
);
  ch_state_e        r_st, w_st;
  mode_e            r_mode, w_mode, r_smode, w_smode, w_upd_mode;
  logic [CNT_W-1:0] r_cnt, w_cnt, r_div, w_div, r_sdiv, w_sdiv, w_upd_div, w_ld;
  logic             r_pend, w_pend, r_strb, w_strb;
  // Values installed on reload or on leaving RUN; a same-cycle write beats the shadow
  assign w_upd_div  = wr_i ? div_i : (r_pend ? r_sdiv : r_div);
  assign w_upd_mode = wr_i ? mode_e'(mode_i) : (r_pend ? r_smode : r_mode);
  assign w_ld       = (w_upd_div == '0) ? '0 : w_upd_div - 1'b1;
  always_comb begin
    w_st    = r_st;
    w_cnt   = r_cnt;
    w_div   = r_div;
    w_mode  = r_mode;
    w_sdiv  = r_sdiv;
    w_smode = r_smode;
    w_pend  = r_pend;
    w_strb  = 1'b0;
    case (r_st)
      IDLE: begin
        w_div  = w_upd_div;
        w_mode = w_upd_mode;
        if (en_i) begin
          w_st  = RUN;
          w_cnt = w_ld;
        end
      end
      RUN: begin
        if (!en_i) begin
          w_st   = IDLE;
          w_div  = w_upd_div;
          w_mode = w_upd_mode;
          w_pend = 1'b0;
        end else if (r_cnt == '0) begin
          w_strb = 1'b1;
          w_div  = w_upd_div;
          w_mode = w_upd_mode;
          w_pend = 1'b0;
          w_st   = (w_upd_mode == ONESHOT) ? DONE : RUN;
          w_cnt  = (w_upd_mode == ONESHOT) ? r_cnt : w_ld;
        end else begin
          w_cnt = r_cnt - 1'b1;
          if (wr_i) begin
            w_sdiv  = div_i;
            w_smode = mode_e'(mode_i);
            w_pend  = 1'b1;
          end
        end
      end
      DONE: begin
        w_div  = w_upd_div;
        w_mode = w_upd_mode;
        w_st   = en_i ? DONE : IDLE;
      end
      default: w_st = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_st    <= IDLE;
      r_cnt   <= '0;
      r_div   <= CNT_W'(1);
      r_mode  <= PERIODIC;
      r_sdiv  <= '0;
      r_smode <= PERIODIC;
      r_pend  <= 1'b0;
      r_strb  <= 1'b0;
    end else begin
      r_st    <= w_st;
      r_cnt   <= w_cnt;
      r_div   <= w_div;
      r_mode  <= w_mode;
      r_sdiv  <= w_sdiv;
      r_smode <= w_smode;
      r_pend  <= w_pend;
      r_strb  <= w_strb;
    end
  end
  assign strb_o = r_strb;
  assign busy_o = (r_st == RUN);
  assign pend_o = r_pend;
endmodule

// File: rtl/strb_gen.sv
// strb_gen: multi-channel programmable strobe generator with a shared cfg port
module strb_gen #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_div_i,
  input  logic              cfg_mode_i,
  input  logic [NUM_CH-1:0] en_i,
  output logic [NUM_CH-1:0] strb_o,
  output logic [NUM_CH-1:0] busy_o
);
  localparam int PW = 2 ** CH_W;
  logic [NUM_CH-1:0] w_pend;
  logic [PW-1:0]     w_pend_x;
  // Unused channel indices read as not pending, so out-of-range requests are accepted and dropped
  assign w_pend_x    = PW'(w_pend);
  assign cfg_ready_o = ~w_pend_x[cfg_ch_i];
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    strb_gen_ch #(.CNT_W(CNT_W)) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .wr_i   (cfg_valid_i && cfg_ready_o && (cfg_ch_i == CH_W'(g))),
      .div_i  (cfg_div_i),
      .mode_i (cfg_mode_i),
      .en_i   (en_i[g]),
      .strb_o (strb_o[g]),
      .busy_o (busy_o[g]),
      .pend_o (w_pend[g])
    );
  end
endmodule

// File: tb/tb_strb_gen.sv
// tb_strb_gen: scoreboard bench comparing strb_gen against a time-based reference model
module tb_strb_gen;
  localparam int NCH = 2, CW = 8, HW = 2;
  logic clk = 1'b0;
  logic rst_i, cfg_valid_i, cfg_ready_o, cfg_mode_i;
  logic [HW-1:0] cfg_ch_i;
  logic [CW-1:0] cfg_div_i;
  logic [NCH-1:0] en_i, strb_o, busy_o;
  always #5 clk = ~clk;
  strb_gen #(.NUM_CH(NCH), .CNT_W(CW), .CH_W(HW)) dut (
    .clk_i(clk), .rst_i(rst_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_ch_i(cfg_ch_i), .cfg_div_i(cfg_div_i), .cfg_mode_i(cfg_mode_i),
    .en_i(en_i), .strb_o(strb_o), .busy_o(busy_o)
  );
  typedef struct packed {logic [1:0] strb; logic [1:0] busy; logic ready;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, k = 0;
  // Model: state 0 idle, 1 run, 2 done; tc = absolute edge index of the next terminal count
  int st[NCH], tc[NCH], ad[NCH], sd[NCH];
  bit am[NCH], sm[NCH], pend[NCH];
  logic [1:0] e_strb, e_busy;
  function automatic int eff(int d);
    return (d == 0) ? 1 : d;
  endfunction
  function automatic bit m_ready(int ch);
    return (ch >= NCH) || !pend[ch];
  endfunction
  function automatic void model_edge();
    bit xfer, wr;
    xfer = cfg_valid_i && m_ready(int'(cfg_ch_i));
    e_strb = '0;
    for (int c = 0; c < NCH; c++) begin
      wr = xfer && (int'(cfg_ch_i) == c);
      if (rst_i) begin
        st[c] = 0; ad[c] = 1; am[c] = 0; sd[c] = 0; sm[c] = 0; pend[c] = 0;
      end else if (st[c] == 0) begin
        if (wr) begin ad[c] = int'(cfg_div_i); am[c] = cfg_mode_i; end
        if (en_i[c]) begin st[c] = 1; tc[c] = k + eff(ad[c]); end
      end else if (st[c] == 1) begin
        if (!en_i[c] || k == tc[c]) begin
          if (wr) begin ad[c] = int'(cfg_div_i); am[c] = cfg_mode_i; end
          else if (pend[c]) begin ad[c] = sd[c]; am[c] = sm[c]; end
          pend[c] = 0;
          if (!en_i[c]) st[c] = 0;
          else begin
            e_strb[c] = 1'b1;
            if (am[c]) st[c] = 2;
            else tc[c] = k + eff(ad[c]);
          end
        end else if (wr) begin
          sd[c] = int'(cfg_div_i); sm[c] = cfg_mode_i; pend[c] = 1;
        end
      end else begin
        if (wr) begin ad[c] = int'(cfg_div_i); am[c] = cfg_mode_i; end
        if (!en_i[c]) st[c] = 0;
      end
      e_busy[c] = (st[c] == 1);
    end
    k++;
  endfunction
  task automatic step(input logic r, input logic v, input int ch, input int d, input logic m,
                      input logic [1:0] en);
    @(posedge clk);
    model_edge();
    #1;
    rst_i = r; cfg_valid_i = v; cfg_ch_i = HW'(ch); cfg_div_i = CW'(d); cfg_mode_i = m; en_i = en;
    q.push_back('{strb: e_strb, busy: e_busy, ready: m_ready(ch)});
  endtask
  task automatic run(input int n, input logic [1:0] en);
    repeat (n) step(1'b0, 1'b0, 0, 0, 1'b0, en);
  endtask
  task automatic cfg(input int ch, input int d, input logic m, input logic [1:0] en);
    step(1'b0, 1'b1, ch, d, m, en);
  endtask
  task automatic rst_cycle();
    step(1'b1, 1'b0, 0, 0, 1'b0, 2'b00);
  endtask
  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %b expected %b", nm, k, act, exp);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("strb_o", strb_o, e.strb);
        chk("busy_o", busy_o, e.busy);
        chk("cfg_ready_o", {1'b0, cfg_ready_o}, {1'b0, e.ready});
      end
    end
  end
  initial begin
    logic [1:0] ren;
    rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_ch_i = '0; cfg_div_i = '0; cfg_mode_i = 1'b0; en_i = '0;
    rst_cycle(); rst_cycle();
    cfg(0, 4, 1'b0, 2'b00); run(16, 2'b01);
    rst_cycle();
    cfg(1, 3, 1'b1, 2'b00); run(8, 2'b10); run(2, 2'b00); run(8, 2'b10);
    rst_cycle();
    cfg(0, 5, 1'b0, 2'b00); run(3, 2'b01);
    repeat (8) cfg(0, 2, 1'b0, 2'b01);
    run(10, 2'b01);
    rst_cycle();
    cfg(0, 0, 1'b0, 2'b00); run(5, 2'b01); cfg(0, 1, 1'b0, 2'b01); run(5, 2'b01);
    rst_cycle();
    cfg(0, 255, 1'b0, 2'b00); run(520, 2'b01);
    rst_cycle();
    cfg(0, 3, 1'b0, 2'b00); run(3, 2'b01); run(3, 2'b00);
    cfg(1, 6, 1'b0, 2'b00); run(4, 2'b10); step(1'b1, 1'b0, 0, 0, 1'b0, 2'b10); run(4, 2'b10);
    cfg(0, 2, 1'b0, 2'b00); cfg(1, 3, 1'b0, 2'b00);
    cfg(3, 7, 1'b1, 2'b11); cfg(2, 1, 1'b1, 2'b11); run(10, 2'b11);
    ren = 2'b00;
    repeat (4000) begin
      for (int b = 0; b < NCH; b++) if ($urandom_range(0, 19) == 0) ren[b] = ~ren[b];
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6)),
           $urandom_range(0, 1) == 1, ren);
    end
    run(3, 2'b00);
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
